// File: rtl/fc_sched_pkg.sv
// Shared constants for the fully-connected layer scheduler: FSM encodings and core count.
package fc_sched_pkg;

    localparam int unsigned NUM_CORE = 4;

    typedef logic [2:0] sched_state_t;

    localparam sched_state_t S_IDLE  = 3'd0;
    localparam sched_state_t S_START = 3'd1;
    localparam sched_state_t S_WAIT  = 3'd2;
    localparam sched_state_t S_STORE = 3'd3;
    localparam sched_state_t S_NEXT  = 3'd4;
    localparam sched_state_t S_DONE  = 3'd5;

    // Busy covers every state that belongs to an in-flight layer except the final DONE pulse.
    function automatic logic state_is_busy(input sched_state_t s);
        return (s != S_IDLE) && (s != S_DONE);
    endfunction

endpackage

// File: rtl/fc_layer_scheduler_if.sv
// Scheduler <-> 4-core data mover handshake: run/count/base out, idle/done/results back.
interface fc_layer_scheduler_if #(
    parameter int unsigned CNT_BIT = 31,
    parameter int unsigned AWIDTH  = 12,
    parameter int unsigned DWIDTH  = 32
);
    logic                mv_run;
    logic [CNT_BIT-1:0]  mv_num_cnt;
    logic [AWIDTH-1:0]   wgt_base;
    logic                mv_idle;
    logic                mv_done;
    logic [DWIDTH-1:0]   result_0;
    logic [DWIDTH-1:0]   result_1;
    logic [DWIDTH-1:0]   result_2;
    logic [DWIDTH-1:0]   result_3;

    modport master (
        output mv_run,
        output mv_num_cnt,
        output wgt_base,
        input  mv_idle,
        input  mv_done,
        input  result_0,
        input  result_1,
        input  result_2,
        input  result_3
    );

    modport slave (
        input  mv_run,
        input  mv_num_cnt,
        input  wgt_base,
        output mv_idle,
        output mv_done,
        output result_0,
        output result_1,
        output result_2,
        output result_3
    );

endinterface

// File: rtl/fc_result_writer.sv
// Captures the four core results of one mover pass and streams them into the result BRAM,
// core 0 first, at addresses grp_idx*4 + k.
module fc_result_writer
    import fc_sched_pkg::*;
#(
    parameter int unsigned GRP_BIT = 16,
    parameter int unsigned AWIDTH  = 12,
    parameter int unsigned DWIDTH  = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cap_i,
    input  logic [DWIDTH-1:0]  res_0_i,
    input  logic [DWIDTH-1:0]  res_1_i,
    input  logic [DWIDTH-1:0]  res_2_i,
    input  logic [DWIDTH-1:0]  res_3_i,
    input  logic [GRP_BIT-1:0] grp_idx_i,
    output logic [AWIDTH-1:0]  addr_o,
    output logic               ce_o,
    output logic               we_o,
    output logic [DWIDTH-1:0]  data_o,
    output logic               wr_done_o
);

    logic [DWIDTH-1:0]  res_q [NUM_CORE];
    logic [1:0]         k_q, k_d;
    logic               active_q, active_d;
    logic [GRP_BIT+1:0] slot;

    always_comb begin
        active_d = active_q;
        k_d      = k_q;
        if (cap_i) begin
            active_d = 1'b1;
            k_d      = 2'd0;
        end else if (active_q) begin
            k_d = k_q + 2'd1;
            if (k_q == 2'd3) begin
                active_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_q <= 1'b0;
            k_q      <= 2'd0;
            for (int i = 0; i < NUM_CORE; i++) begin
                res_q[i] <= '0;
            end
        end else begin
            active_q <= active_d;
            k_q      <= k_d;
            if (cap_i) begin
                res_q[0] <= res_0_i;
                res_q[1] <= res_1_i;
                res_q[2] <= res_2_i;
                res_q[3] <= res_3_i;
            end
        end
    end

    // Address wraps silently at the BRAM depth; overwriting earlier groups is intended.
    assign slot      = {grp_idx_i, k_q};
    assign addr_o    = active_q ? AWIDTH'(slot) : '0;
    assign ce_o      = active_q;
    assign we_o      = active_q;
    assign data_o    = active_q ? res_q[k_q] : '0;
    assign wr_done_o = active_q && (k_q == 2'd3);

endmodule

// File: rtl/fc_layer_scheduler.sv
// Sequences one fully-connected layer: one mover pass per 4-node group, results stored serially.
module fc_layer_scheduler
    import fc_sched_pkg::*;
#(
    parameter int unsigned CNT_BIT = 31,
    parameter int unsigned GRP_BIT = 16,
    parameter int unsigned AWIDTH  = 12,
    parameter int unsigned DWIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_run,
    input  logic [CNT_BIT-1:0]   i_num_in,
    input  logic [GRP_BIT-1:0]   i_num_grp,
    output logic                 o_idle,
    output logic                 o_busy,
    output logic                 o_done,
    output logic [GRP_BIT-1:0]   o_grp_idx,
    fc_layer_scheduler_if.master mv,
    output logic [AWIDTH-1:0]    addr_r,
    output logic                 ce_r,
    output logic                 we_r,
    output logic [DWIDTH-1:0]    d_r
);

    sched_state_t       state_q, state_d;
    logic [CNT_BIT-1:0] num_in_q, num_in_d;
    logic [GRP_BIT-1:0] num_grp_q, num_grp_d;
    logic [GRP_BIT-1:0] grp_idx_q, grp_idx_d;
    logic [AWIDTH-1:0]  wgt_base_q, wgt_base_d;
    logic               cap;
    logic               wr_done;
    logic               last_grp;

    assign last_grp = (grp_idx_q == (num_grp_q - GRP_BIT'(1)));
    assign cap      = (state_q == S_WAIT) && mv.mv_done;

    always_comb begin
        state_d    = state_q;
        num_in_d   = num_in_q;
        num_grp_d  = num_grp_q;
        grp_idx_d  = grp_idx_q;
        wgt_base_d = wgt_base_q;
        case (state_q)
            S_IDLE: begin
                if (i_run) begin
                    num_in_d  = i_num_in;
                    num_grp_d = i_num_grp;
                    // An empty layer still reports completion but never touches the mover.
                    if ((i_num_in == '0) || (i_num_grp == '0)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_START;
                    end
                end
            end
            S_START: begin
                if (mv.mv_idle) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (mv.mv_done) begin
                    state_d = S_STORE;
                end
            end
            S_STORE: begin
                if (wr_done) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (last_grp) begin
                    state_d = S_DONE;
                end else begin
                    grp_idx_d  = grp_idx_q + GRP_BIT'(1);
                    // Running sum avoids a grp_idx*num_in multiplier; wraps mod 2^AWIDTH.
                    wgt_base_d = wgt_base_q + num_in_q[AWIDTH-1:0];
                    state_d    = S_START;
                end
            end
            S_DONE: begin
                grp_idx_d  = '0;
                wgt_base_d = '0;
                state_d    = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            num_in_q   <= '0;
            num_grp_q  <= '0;
            grp_idx_q  <= '0;
            wgt_base_q <= '0;
        end else begin
            state_q    <= state_d;
            num_in_q   <= num_in_d;
            num_grp_q  <= num_grp_d;
            grp_idx_q  <= grp_idx_d;
            wgt_base_q <= wgt_base_d;
        end
    end

    fc_result_writer #(
        .GRP_BIT (GRP_BIT),
        .AWIDTH  (AWIDTH),
        .DWIDTH  (DWIDTH)
    ) u_writer (
        .clk       (clk),
        .reset     (reset),
        .cap_i     (cap),
        .res_0_i   (mv.result_0),
        .res_1_i   (mv.result_1),
        .res_2_i   (mv.result_2),
        .res_3_i   (mv.result_3),
        .grp_idx_i (grp_idx_q),
        .addr_o    (addr_r),
        .ce_o      (ce_r),
        .we_o      (we_r),
        .data_o    (d_r),
        .wr_done_o (wr_done)
    );

    assign o_idle        = (state_q == S_IDLE);
    assign o_busy        = state_is_busy(state_q);
    assign o_done        = (state_q == S_DONE);
    assign o_grp_idx     = grp_idx_q;
    assign mv.mv_run     = (state_q == S_START) && mv.mv_idle;
    assign mv.mv_num_cnt = num_in_q;
    assign mv.wgt_base   = wgt_base_q;

endmodule
